// File: rtl/fifo_wr_arbiter_if.sv
// Bundle carrying the requester handshakes and the FIFO write port of fifo_wr_arbiter.
// master: requesters plus FIFO full flag (testbench/fabric side); slave: the arbiter.
// busy/owner expose the arbiter's grant state to observers.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     full;
  logic                     wr_en;
  logic [WIDTH-1:0]         wr_data;
  logic                     busy;
  logic [OW-1:0]            owner;

  modport master (
    output req_valid, req_data, full,
    input  req_ready, wr_en, wr_data, busy, owner
  );

  modport slave (
    input  req_valid, req_data, full,
    output req_ready, wr_en, wr_data, busy, owner
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters, bursts of <= MAX_BURST beats.
// Latency: one IDLE cycle per grant; beats then pass combinationally from the owner to wr_en/wr_data.
// Backpressure: full stalls the owner (req_ready=0, wr_en=0) without losing the grant.
// Optional statistics counters (stat_beats, stat_stall) are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               wr_clk,
  input  logic               wr_rst,
`ifdef FIFO_ARB_STATS_EN
  fifo_wr_arbiter_if.slave   bus,
  output logic [31:0]        stat_beats,
  output logic [15:0]        stat_stall
`else
  fifo_wr_arbiter_if.slave   bus
`endif
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t        state_q;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] last_owner_q;
  logic [BW-1:0] beat_cnt_q;

  logic          grant_vld;
  logic [OW-1:0] grant_idx;
  logic [OW-1:0] cand_idx;
  int            cand;
  logic          own_vld;
  logic          xfer;

  // Owner's beat moves only in BURST, when the FIFO has room and reset is not asserted.
  assign own_vld = bus.req_valid[owner_q];
  assign xfer    = (state_q == S_BURST) && own_vld && !bus.full && !wr_rst;

  assign bus.wr_en     = xfer;
  assign bus.req_ready = xfer ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.wr_data   = (state_q == S_BURST) ? bus.req_data[int'(owner_q)*WIDTH +: WIDTH] : '0;
  assign bus.busy      = (state_q == S_BURST);
  assign bus.owner     = owner_q;

  // Round-robin search: the smallest offset after last_owner with a valid request wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand     = (int'(last_owner_q) + k) % NUM_REQ;
      cand_idx = OW'(cand);
      if (bus.req_valid[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Grant FSM: IDLE picks the next owner, BURST counts beats and releases on limit or drop.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            owner_q    <= grant_idx;
            beat_cnt_q <= '0;
            state_q    <= S_BURST;
          end
        end
        S_BURST: begin
          if (xfer) begin
            if (beat_cnt_q == BW'(MAX_BURST - 1)) begin
              last_owner_q <= owner_q;
              state_q      <= S_IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end else if (!own_vld) begin
            last_owner_q <= owner_q;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [31:0] stat_beats_q;
  logic [15:0] stat_stall_q;

  // Accepted-write counter wraps; stall counter saturates so long stalls stay visible.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      stat_beats_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (xfer) begin
        stat_beats_q <= stat_beats_q + 32'd1;
      end
      if ((state_q == S_BURST) && own_vld && bus.full && (stat_stall_q != 16'hFFFF)) begin
        stat_stall_q <= stat_stall_q + 16'd1;
      end
    end
  end

  assign stat_beats = stat_beats_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: the stimulus process predicts each cycle's outputs
// from the arbitration rules and queues them; a negedge monitor pops and compares.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic wr_clk = 1'b0;
  logic wr_rst;
  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

`ifdef FIFO_ARB_STATS_EN
  logic [31:0] stat_beats;
  logic [15:0] stat_stall;
  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .bus(bus),
    .stat_beats(stat_beats), .stat_stall(stat_stall));
`else
  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .bus(bus));
`endif

  typedef struct {
    logic        en;
    logic [7:0]  data;
    logic        chk_data;
    logic [3:0]  rdy;
    logic        busy;
    logic [1:0]  owner;
    logic [31:0] beats;
    logic [15:0] stall;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: who holds the grant and how many beats it has used.
  bit   m_busy;
  int   m_owner, m_last, m_cnt;
  int   m_beats, m_stall;
  // Requester side.
  logic [3:0] want, prev_v, prev_rdy;
  logic [7:0] dat[N];
  bit   full_r, rst_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired @%0t", name, $time);
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = N - 1; m_cnt = 0;
  endtask

  // One clock cycle: drive inputs, queue the predicted outputs, advance the model.
  task automatic cyc();
    logic [3:0] v, held, rdy;
    bit en, found;
    exp_t e;
    int c;
    for (int i = 0; i < N; i++) if (prev_rdy[i]) dat[i] = dat[i] + 8'd1;
    held = rst_r ? 4'b0 : (prev_v & ~prev_rdy);
    v = held | want;
    wr_rst = rst_r;
    bus.full = full_r;
    bus.req_valid = v;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = dat[i];

    en  = !rst_r && m_busy && v[m_owner] && !full_r;
    rdy = en ? (4'b0001 << m_owner) : 4'b0000;
    e.en = en; e.rdy = rdy; e.busy = m_busy; e.owner = 2'(m_owner);
    e.chk_data = m_busy; e.data = dat[m_owner];
    e.beats = 32'(m_beats); e.stall = 16'(m_stall);
    q.push_back(e);

    if (rst_r) begin
      m_beats = 0; m_stall = 0;
    end else begin
      if (en) m_beats++;
      if (m_busy && v[m_owner] && full_r && m_stall < 65535) m_stall++;
    end

    if (rst_r) begin
      model_reset();
    end else if (!m_busy) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && v[c]) begin
          found = 1; m_owner = c; m_busy = 1; m_cnt = 0;
        end
      end
    end else if (en) begin
      if (m_cnt == MB - 1) begin m_busy = 0; m_last = m_owner; end
      else m_cnt++;
    end else if (!v[m_owner]) begin
      m_busy = 0; m_last = m_owner;
    end
    prev_v = v;
    prev_rdy = rdy;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_reset();
    rst_r = 1; cyc(); rst_r = 0;
  endtask

  // Let pending beats finish and the grant lapse.
  task automatic drain();
    bit ok;
    want = 4'b0; full_r = 0; ok = 0;
    for (int i = 0; i < 60; i++) begin
      if ((prev_v & ~prev_rdy) == 4'b0 && !m_busy) begin ok = 1; break; end
      cyc();
    end
    if (!ok) timeout("drain");
    run(2);
  endtask

  // Monitor: compares the DUT against the queued prediction on each falling edge.
  always @(negedge wr_clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("wr_en", 32'(bus.wr_en), 32'(e.en));
      check("req_ready", 32'(bus.req_ready), 32'(e.rdy));
      check("busy", 32'(bus.busy), 32'(e.busy));
      if (e.busy) check("owner", 32'(bus.owner), 32'(e.owner));
      if (e.chk_data) check("wr_data", 32'(bus.wr_data), 32'(e.data));
`ifdef FIFO_ARB_STATS_EN
      check("stat_beats", stat_beats, e.beats);
      check("stat_stall", 32'(stat_stall), 32'(e.stall));
`endif
    end
  end

  initial begin
    bit ok;
    wr_rst = 1; bus.full = 0; bus.req_valid = '0; bus.req_data = '0;
    model_reset(); m_beats = 0; m_stall = 0;
    want = 4'b0; prev_v = 4'b0; prev_rdy = 4'b0; full_r = 0; rst_r = 1;
    for (int i = 0; i < N; i++) dat[i] = 8'(i * 16);
    @(posedge wr_clk); #1;

    // Reset held with every requester valid, then release: grant to 0 after one IDLE cycle.
    want = 4'hF; rst_r = 1; run(2);
    rst_r = 0; run(3);
    want = 4'h0; pulse_reset(); run(1);

    // Single requester 2 streaming A0, A1, ...
    dat[2] = 8'hA0; want = 4'b0100; run(12);
    drain();

    // All requesters: grant order 0,1,2,3,0.
    pulse_reset(); want = 4'hF; run(21);
    drain();

    // Requester 1 stalled by full after two beats for three cycles.
    pulse_reset(); want = 4'b0010; ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_busy && m_cnt == 2) begin ok = 1; break; end
      cyc();
    end
    if (!ok) timeout("stall_setup");
    full_r = 1; run(3); full_r = 0; run(3);
    drain();

    // Requester 0 drops after one beat while 3 waits.
    pulse_reset(); want = 4'b1001; ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_busy && m_owner == 0) begin ok = 1; break; end
      cyc();
    end
    if (!ok) timeout("drop_setup");
    want = 4'b1000; run(8);
    drain();

    // Reset pulsed mid-burst of requester 2; afterwards requester 0 wins.
    want = 4'b0100; ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_busy && m_owner == 2 && m_cnt == 2) begin ok = 1; break; end
      cyc();
    end
    if (!ok) timeout("rst_setup");
    want = 4'b0101; pulse_reset(); run(6);
    drain();

    // Random traffic, backpressure and occasional reset.
    for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 7) == 0) want = 4'($urandom_range(0, 15));
      full_r = ($urandom_range(0, 3) == 0);
      rst_r  = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst_r = 0;
    drain();

    @(negedge wr_clk); @(negedge wr_clk);
    if (q.size() != 0) timeout("scoreboard_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
